// File: rtl/siso_maxlog_stream_if.sv
// Stream bundle for the max-log-MAP SISO decoder:
// symbol input, LLR output and status lines.
interface siso_maxlog_stream_if #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 10,
  parameter int LEN_W = 7
);
  logic [LEN_W-1:0]        blk_len;
  logic                    term;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  sys;
  logic signed [IN_W-1:0]  enc;
  logic signed [IN_W-1:0]  apr;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] llr;
  logic signed [OUT_W-1:0] ext;
  logic [LEN_W-1:0]        out_idx;
  logic                    busy;
  logic                    done;

  modport master (
    output blk_len, term, in_valid,
    output sys, enc, apr, out_ready,
    input  in_ready, out_valid, llr,
    input  ext, out_idx, busy, done
  );

  modport slave (
    input  blk_len, term, in_valid,
    input  sys, enc, apr, out_ready,
    output in_ready, out_valid, llr,
    output ext, out_idx, busy, done
  );
endinterface

// File: rtl/siso_maxlog_stream.sv
// Streaming max-log-MAP SISO for the 4-state RSC code:
// block load, forward alpha pass, backward beta pass with LLR out.
module siso_maxlog_stream #(
  parameter int IN_W    = 6,
  parameter int MET_W   = 12,
  parameter int OUT_W   = 10,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic clk_i,
  input  logic reset_n_i,
  siso_maxlog_stream_if.slave bus
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int W2 = MET_W + 2;

  typedef logic signed [MET_W-1:0] met_t;
  typedef logic signed [IN_W-1:0]  sym_t;
  typedef enum logic [2:0] {
    IDLE, LOAD, FWD, BWD, DONE
  } state_t;

  localparam met_t NEG = met_t'(-(2 ** (MET_W - 2)));

  function automatic met_t sat_met(
    logic signed [MET_W:0] s
  );
    if (s[MET_W] == s[MET_W-1])
      return s[MET_W-1:0];
    return s[MET_W] ? {1'b1, {(MET_W-1){1'b0}}}
                    : {1'b0, {(MET_W-1){1'b1}}};
  endfunction

  function automatic met_t sat_add(met_t a, met_t b);
    return sat_met((MET_W+1)'(a) + (MET_W+1)'(b));
  endfunction

  function automatic met_t sat_sub(met_t a, met_t b);
    return sat_met((MET_W+1)'(a) - (MET_W+1)'(b));
  endfunction

  function automatic met_t max2(met_t a, met_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(
    logic signed [W2-1:0] x
  );
    logic [W2-OUT_W:0] top;
    top = x[W2-1:OUT_W-1];
    if (&top || ~|top)
      return x[OUT_W-1:0];
    return x[W2-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                   : {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  state_t           state;
  logic [LEN_W-1:0] k;
  logic [LEN_W-1:0] klen;
  logic             term_q;
  logic             bwd_left;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;
  logic signed [OUT_W-1:0] llr_q;
  logic signed [OUT_W-1:0] ext_q;
  logic [LEN_W-1:0] idx_q;

  sym_t sys_mem [MAX_LEN];
  sym_t enc_mem [MAX_LEN];
  sym_t apr_mem [MAX_LEN];
  met_t alpha_mem [MAX_LEN][4];

  met_t alpha [4];
  met_t beta  [4];
  met_t am    [4];
  met_t anx   [4];
  met_t anorm [4];
  met_t bnx   [4];
  met_t bnorm [4];
  met_t g     [2][2];
  met_t ta    [4][2];
  met_t tb    [4][2];
  met_t sa, ee, l0, l1;
  sym_t cs, ce, ca;
  logic signed [W2-1:0] llr_w, ext_w;

  logic [LEN_W-1:0] klen_new, k_lim, widx;
  logic             ld_we, last_ld, slot_free;

  // K=0 behaves as a single step, oversize blocks are clamped
  always_comb begin
    klen_new = bus.blk_len;
    if (bus.blk_len == '0)
      klen_new = LEN_W'(1);
    else if (bus.blk_len > LEN_W'(MAX_LEN))
      klen_new = LEN_W'(MAX_LEN);
    k_lim = (state == IDLE) ? klen_new : klen;
    widx = (state == IDLE) ? '0 : k;
    ld_we = in_ready_q & bus.in_valid;
    last_ld = (widx == k_lim - LEN_W'(1));
    slot_free = !out_valid_q || bus.out_ready;
  end

  always_comb begin
    cs = sys_mem[k[AW-1:0]];
    ce = enc_mem[k[AW-1:0]];
    ca = apr_mem[k[AW-1:0]];
    am = alpha_mem[k[AW-1:0]];
    sa = met_t'(cs) + met_t'(ca);
    ee = met_t'(ce);
    g[0][0] = -sa - ee;
    g[0][1] = ee - sa;
    g[1][0] = sa - ee;
    g[1][1] = sa + ee;
    // state n = {u, s[1]}: predecessors differ only in s[0]
    for (int n = 0; n < 4; n++)
      anx[n] = max2(
        sat_add(alpha[(n%2)*2], g[n/2][n/2]),
        sat_add(alpha[(n%2)*2+1], g[n/2][1-n/2]));
    for (int n = 0; n < 4; n++)
      anorm[n] = sat_sub(anx[n], anx[0]);
    for (int s = 0; s < 4; s++)
      for (int u = 0; u < 2; u++) begin
        ta[s][u] = sat_add(
          sat_add(am[s], g[u][u ^ (s%2)]),
          beta[u*2 + s/2]);
        tb[s][u] = sat_add(
          g[u][u ^ (s%2)], beta[u*2 + s/2]);
      end
    for (int s = 0; s < 4; s++)
      bnx[s] = max2(tb[s][0], tb[s][1]);
    for (int s = 0; s < 4; s++)
      bnorm[s] = sat_sub(bnx[s], bnx[0]);
    l1 = max2(max2(ta[0][1], ta[1][1]),
              max2(ta[2][1], ta[3][1]));
    l0 = max2(max2(ta[0][0], ta[1][0]),
              max2(ta[2][0], ta[3][0]));
    llr_w = W2'(l1) - W2'(l0);
    ext_w = llr_w - W2'(sa) - W2'(sa);
  end

  always_ff @(posedge clk_i) begin
    if (ld_we) begin
      sys_mem[widx[AW-1:0]] <= bus.sys;
      enc_mem[widx[AW-1:0]] <= bus.enc;
      apr_mem[widx[AW-1:0]] <= bus.apr;
    end
    if (state == FWD)
      alpha_mem[k[AW-1:0]] <= alpha;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      k           <= '0;
      klen        <= '0;
      term_q      <= 1'b0;
      bwd_left    <= 1'b0;
      alpha       <= '{default: '0};
      beta        <= '{default: '0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      llr_q       <= '0;
      ext_q       <= '0;
      idx_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, LOAD: begin
          if (ld_we) begin
            if (state == IDLE) begin
              klen   <= klen_new;
              term_q <= bus.term;
            end
            if (last_ld) begin
              state      <= FWD;
              k          <= '0;
              alpha      <= '{'0, NEG, NEG, NEG};
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              state <= LOAD;
              k     <= widx + LEN_W'(1);
            end
          end
        end
        FWD: begin
          alpha <= anorm;
          if (k == klen - LEN_W'(1)) begin
            state    <= BWD;
            bwd_left <= 1'b1;
            beta     <= term_q ? '{'0, NEG, NEG, NEG}
                               : '{default: '0};
          end else begin
            k <= k + LEN_W'(1);
          end
        end
        BWD: begin
          // recursion advances only when the output slot frees up
          if (slot_free) begin
            if (bwd_left) begin
              out_valid_q <= 1'b1;
              llr_q       <= sat_out(llr_w);
              ext_q       <= sat_out(ext_w);
              idx_q       <= k;
              beta        <= bnorm;
              if (k == '0)
                bwd_left <= 1'b0;
              else
                k <= k - LEN_W'(1);
            end else begin
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.llr       = llr_q;
  assign bus.ext       = ext_q;
  assign bus.out_idx   = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_siso_maxlog_stream.sv
// Bench for siso_maxlog_stream: vector table, reference
// max-log-MAP model feeding a scoreboard, reset corner case.
module tb_siso_maxlog_stream;
  localparam int IN_W = 6;
  localparam int MET_W = 12;
  localparam int OUT_W = 10;
  localparam int MAX_LEN = 64;
  localparam int LEN_W = 7;
  localparam int NEGV = -(2 ** (MET_W - 2));

  typedef struct {
    int len; bit term; bit rnd;
    int sv; int ev; int av;
    int seed; bit stall; int exp_n;
  } vec_t;

  typedef struct {
    int llr; int ext; int idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  int ss[MAX_LEN];
  int se[MAX_LEN];
  int sp[MAX_LEN];
  vec_t vecs[8];

  always #5 clk = ~clk;

  siso_maxlog_stream_if #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)
  ) bus ();

  siso_maxlog_stream #(
    .IN_W(IN_W), .MET_W(MET_W), .OUT_W(OUT_W),
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .bus(bus)
  );

  task automatic chk(input bit ok, input string nm,
                     input int got, input int want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, got, want);
    end
  endtask

  function automatic int sat(input int x, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model(input int kk, input bit term);
    int am[MAX_LEN][4];
    int a[4], b[4], nx[4], nb[4], lu[2];
    int base, g, t, sa, ns, p, full;
    a = '{0, NEGV, NEGV, NEGV};
    for (int k = 0; k < kk; k++) begin
      for (int s = 0; s < 4; s++) am[k][s] = a[s];
      sa = ss[k] + sp[k];
      nx = '{default: -100000};
      for (int s = 0; s < 4; s++)
        for (int u = 0; u < 2; u++) begin
          ns = u * 2 + s / 2;
          p = u ^ (s % 2);
          g = (u ? sa : -sa) + (p ? se[k] : -se[k]);
          t = sat(a[s] + g, MET_W);
          if (t > nx[ns]) nx[ns] = t;
        end
      base = nx[0];
      for (int n = 0; n < 4; n++)
        a[n] = sat(nx[n] - base, MET_W);
    end
    if (term) b = '{0, NEGV, NEGV, NEGV};
    else b = '{0, 0, 0, 0};
    for (int k = kk - 1; k >= 0; k--) begin
      sa = ss[k] + sp[k];
      lu = '{-100000, -100000};
      nb = '{default: -100000};
      for (int s = 0; s < 4; s++)
        for (int u = 0; u < 2; u++) begin
          ns = u * 2 + s / 2;
          p = u ^ (s % 2);
          g = (u ? sa : -sa) + (p ? se[k] : -se[k]);
          t = sat(sat(am[k][s] + g, MET_W) + b[ns], MET_W);
          if (t > lu[u]) lu[u] = t;
          t = sat(g + b[ns], MET_W);
          if (t > nb[s]) nb[s] = t;
        end
      full = lu[1] - lu[0];
      sbq.push_back('{sat(full, OUT_W),
                      sat(full - 2 * sa, OUT_W), k});
      base = nb[0];
      for (int n = 0; n < 4; n++)
        b[n] = sat(nb[n] - base, MET_W);
    end
  endtask

  task automatic fill(input vec_t v, input int n);
    int unsigned st;
    st = v.seed;
    for (int i = 0; i < n; i++) begin
      if (v.rnd) begin
        st = st * 1103515245 + 12345;
        ss[i] = int'((st >> 16) % 63) - 31;
        st = st * 1103515245 + 12345;
        se[i] = int'((st >> 16) % 63) - 31;
        st = st * 1103515245 + 12345;
        sp[i] = int'((st >> 16) % 63) - 31;
      end else begin
        ss[i] = v.sv;
        se[i] = v.ev;
        sp[i] = v.av;
      end
    end
  endtask

  task automatic load(input int len, input bit term,
                      input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.blk_len = LEN_W'(len);
      bus.term = term;
      bus.sys = IN_W'(ss[i]);
      bus.enc = IN_W'(se[i]);
      bus.apr = IN_W'(sp[i]);
      w = 0;
      while (!bus.in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (!bus.in_ready)
        chk(1'b0, "in_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk(bus.in_ready == 1'b0, "in_ready_drop",
        int'(bus.in_ready), 0);
    chk(bus.busy == 1'b1, "busy_after_load",
        int'(bus.busy), 1);
  endtask

  task automatic collect(input vec_t v, input int vi,
                         output int got);
    int step;
    bit held, seen;
    exp_t h, e;
    int ol, oe, oi;
    got = 0; step = 0; held = 0; seen = 0;
    h = '{0, 0, 0};
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 * MAX_LEN + 100 && !seen;
         cyc++) begin
      @(negedge clk);
      ol = int'(bus.llr);
      oe = int'(bus.ext);
      oi = int'(bus.out_idx);
      if (bus.done) begin
        seen = 1;
      end else begin
        if (held)
          chk(bus.out_valid && ol == h.llr && oe == h.ext
              && oi == h.idx, "stall_hold", ol, h.llr);
        held = 0;
        if (bus.out_valid && bus.out_ready) begin
          if (sbq.size() == 0) begin
            chk(1'b0, "unexpected_output", oi, -1);
          end else begin
            e = sbq.pop_front();
            chk(ol == e.llr, "llr", ol, e.llr);
            chk(oe == e.ext, "ext", oe, e.ext);
            chk(oi == e.idx, "out_idx", oi, e.idx);
          end
          if (vi == 0) begin
            chk(ol == 12, "k1_llr", ol, 12);
            chk(oe == 4, "k1_ext", oe, 4);
          end
          if (vi == 1) begin
            chk(ol < 0, "zero_cw_llr_neg", ol, -1);
            chk(oe <= 0, "zero_cw_ext_nonpos", oe, 0);
          end
          if (vi == 2)
            chk(ol >= 0, "sat_llr_no_wrap", ol, 0);
          got++;
        end else if (bus.out_valid) begin
          held = 1;
          h = '{ol, oe, oi};
        end
        @(posedge clk); #1;
        step++;
        bus.out_ready = !v.stall || (step % 4 == 0)
                        || (step % 4 == 3);
      end
    end
    chk(seen, "done_timeout", int'(seen), 1);
    chk(got == v.exp_n, "out_count", got, v.exp_n);
    chk(sbq.size() == 0, "sb_left", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int n, got;
    v = vecs[vi];
    n = (v.len == 0) ? 1 :
        (v.len > MAX_LEN) ? MAX_LEN : v.len;
    fill(v, n);
    model(n, v.term);
    load(v.len, v.term, n);
    collect(v, vi, got);
    @(negedge clk);
    chk(bus.done == 1'b0, "done_one_cycle",
        int'(bus.done), 0);
    chk(bus.in_ready == 1'b1, "idle_ready",
        int'(bus.in_ready), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk(bus.out_valid == 1'b0, {tag, "_out_valid"},
        int'(bus.out_valid), 0);
    chk(bus.llr == '0, {tag, "_llr"}, int'(bus.llr), 0);
    chk(bus.ext == '0, {tag, "_ext"}, int'(bus.ext), 0);
    chk(bus.out_idx == '0, {tag, "_idx"},
        int'(bus.out_idx), 0);
    chk(bus.busy == 1'b0, {tag, "_busy"},
        int'(bus.busy), 0);
    chk(bus.done == 1'b0, {tag, "_done"},
        int'(bus.done), 0);
    chk(bus.in_ready == 1'b1, {tag, "_in_ready"},
        int'(bus.in_ready), 1);
  endtask

  initial begin
    vec_t v;
    bit found;
    bus.in_valid = 1'b0;
    bus.blk_len = '0;
    bus.term = 1'b0;
    bus.sys = '0;
    bus.enc = '0;
    bus.apr = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{len:1, term:0, rnd:0, sv:3, ev:2, av:1,
                seed:0, stall:0, exp_n:1};
    vecs[1] = '{len:8, term:1, rnd:0, sv:-4, ev:-4, av:0,
                seed:0, stall:0, exp_n:8};
    vecs[2] = '{len:16, term:0, rnd:0, sv:31, ev:31, av:31,
                seed:0, stall:0, exp_n:16};
    vecs[3] = '{len:8, term:1, rnd:1, sv:0, ev:0, av:0,
                seed:1234, stall:0, exp_n:8};
    vecs[4] = '{len:8, term:1, rnd:1, sv:0, ev:0, av:0,
                seed:1234, stall:1, exp_n:8};
    vecs[5] = '{len:0, term:0, rnd:1, sv:0, ev:0, av:0,
                seed:99, stall:0, exp_n:1};
    vecs[6] = '{len:MAX_LEN + 5, term:1, rnd:1, sv:0,
                ev:0, av:0, seed:4321, stall:1,
                exp_n:MAX_LEN};
    vecs[7] = '{len:13, term:0, rnd:1, sv:0, ev:0, av:0,
                seed:777, stall:1, exp_n:13};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int vi = 0; vi < 8; vi++)
      run_vec(vi);

    v = '{len:8, term:1, rnd:1, sv:0, ev:0, av:0,
          seed:55, stall:0, exp_n:8};
    fill(v, 8);
    load(8, 1'b1, 8);
    bus.out_ready = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_idx == LEN_W'(3))
        found = 1;
    end
    chk(found, "reach_bwd_k3", int'(found), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    reset_n = 1'b1;
    bus.out_ready = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
